// File: rtl/trng_sample_ctrl.sv
// Ring-oscillator sampling controller: warm-up, strobed sampling,
// optional von Neumann debiasing, repetition-count health test, byte packing.
module trng_sample_ctrl #(
    parameter int WARMUP_CYCLES = 16,
    parameter int SAMPLE_DIV    = 8,
    parameter int OUT_WIDTH     = 8,
    parameter int REP_LIMIT     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 vn_bypass,
    input  logic                 ro_raw,
    output logic                 ro_activate,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 health_fail,
    output logic                 busy
);

    localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int BW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        SAMPLE,
        HOLD,
        FAIL
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 sync2;
    logic [WW-1:0]        warm_cnt;
    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [RW-1:0]        rep_cnt;
    logic                 prev_s;
    logic [OUT_WIDTH-1:0] sh_reg;
    logic                 vn_have;
    logic                 vn_first;
    logic                 bypass_q;

    logic                 strobe;
    logic [RW-1:0]        rep_next;
    logic                 trip;
    logic                 vn_restart;
    logic                 acc_valid;
    logic                 acc_bit;
    logic                 word_done;
    logic [OUT_WIDTH-1:0] sh_next;

    always_comb begin
        strobe     = (state == SAMPLE) && (div_cnt == DW'(SAMPLE_DIV - 1));
        rep_next   = ((rep_cnt != '0) && (sync2 == prev_s)) ?
                     rep_cnt + RW'(1) : RW'(1);
        trip       = strobe && (rep_next == RW'(REP_LIMIT));
        vn_restart = (vn_bypass != bypass_q);
        acc_valid  = 1'b0;
        acc_bit    = 1'b0;
        if (vn_bypass) begin
            acc_valid = strobe;
            acc_bit   = sync2;
        end else begin
            // second sample of a pair; only 01 and 10 produce a bit
            acc_valid = strobe && vn_have && !vn_restart && (vn_first != sync2);
            acc_bit   = vn_first;
        end
        sh_next   = {sh_reg[OUT_WIDTH-2:0], acc_bit};
        word_done = acc_valid && (bit_cnt == BW'(OUT_WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            warm_cnt    <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            rep_cnt     <= '0;
            prev_s      <= 1'b0;
            sh_reg      <= '0;
            vn_have     <= 1'b0;
            vn_first    <= 1'b0;
            bypass_q    <= 1'b0;
            ro_activate <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            health_fail <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync1    <= ro_raw;
            sync2    <= sync1;
            bypass_q <= vn_bypass;
            if (state inside {WARMUP, SAMPLE, HOLD} && !enable) begin
                state       <= IDLE;
                ro_activate <= 1'b0;
                out_valid   <= 1'b0;
                busy        <= 1'b0;
                bit_cnt     <= '0;
                vn_have     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (enable) begin
                            state       <= WARMUP;
                            ro_activate <= 1'b1;
                            busy        <= 1'b1;
                            warm_cnt    <= '0;
                            rep_cnt     <= '0;
                        end
                    end
                    WARMUP: begin
                        if (warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
                            state   <= SAMPLE;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                            vn_have <= 1'b0;
                        end else begin
                            warm_cnt <= warm_cnt + WW'(1);
                        end
                    end
                    SAMPLE: begin
                        div_cnt <= strobe ? '0 : div_cnt + DW'(1);
                        if (strobe) begin
                            prev_s  <= sync2;
                            rep_cnt <= rep_next;
                        end
                        if (trip) begin
                            state       <= FAIL;
                            health_fail <= 1'b1;
                            ro_activate <= 1'b0;
                            busy        <= 1'b0;
                            out_valid   <= 1'b0;
                            out_data    <= '0;
                        end else begin
                            if (!vn_bypass && strobe) begin
                                if (vn_have && !vn_restart) begin
                                    vn_have <= 1'b0;
                                end else begin
                                    vn_have  <= 1'b1;
                                    vn_first <= sync2;
                                end
                            end else if (vn_restart) begin
                                vn_have <= 1'b0;
                            end
                            if (acc_valid) begin
                                sh_reg  <= sh_next;
                                bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
                            end
                            if (word_done) begin
                                out_data  <= sh_next;
                                out_valid <= 1'b1;
                                state     <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state     <= SAMPLE;
                            out_valid <= 1'b0;
                            bit_cnt   <= '0;
                            div_cnt   <= '0;
                            vn_have   <= 1'b0;
                        end
                    end
                    FAIL: begin
                        state <= FAIL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Directed bench for trng_sample_ctrl: a default-parameter instance for
// start-up timing and a fast instance (warm-up 4, divider 2) for the rest.
module tb_trng_sample_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, vn_bypass, ro_raw, out_ready;
    logic       ro_activate, out_valid, health_fail, busy;
    logic [7:0] out_data;

    logic       d_rst, d_enable, d_vn_bypass, d_ro_raw, d_out_ready;
    logic       d_ro_activate, d_out_valid, d_health_fail, d_busy;
    logic [7:0] d_out_data;

    int n_cmp = 0;
    int n_bad = 0;

    trng_sample_ctrl #(
        .WARMUP_CYCLES(4), .SAMPLE_DIV(2), .OUT_WIDTH(8), .REP_LIMIT(32)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .vn_bypass(vn_bypass),
        .ro_raw(ro_raw), .ro_activate(ro_activate), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .health_fail(health_fail), .busy(busy)
    );

    trng_sample_ctrl dut_dflt (
        .clk(clk), .rst(d_rst), .enable(d_enable), .vn_bypass(d_vn_bypass),
        .ro_raw(d_ro_raw), .ro_activate(d_ro_activate), .out_data(d_out_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .health_fail(d_health_fail), .busy(d_busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // bit i lands two edges before its strobe; strobes are 2 cycles apart
    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ro_raw = bits[n-1-i];
            if (i < n - 1) tick(2);
        end
    endtask

    task automatic reset_small;
        rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        d_rst = 1'b1; d_enable = 1'b1; d_vn_bypass = 1'b1;
        d_ro_raw = 1'b1; d_out_ready = 1'b0;
        rst = 1'b1; enable = 1'b1; vn_bypass = 1'b1; ro_raw = 1'b0;
        out_ready = 1'b0;
        tick(2);
        n_cmp++; if (d_ro_activate !== 1'b0) begin n_bad++; $display("FAIL rst_ro_act: got %b want 0", d_ro_activate); end
        n_cmp++; if (d_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", d_out_valid); end
        n_cmp++; if (d_health_fail !== 1'b0) begin n_bad++; $display("FAIL rst_health: got %b want 0", d_health_fail); end
        n_cmp++; if (d_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", d_busy); end
        n_cmp++; if (d_out_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", d_out_data); end
        n_cmp++; if (ro_activate !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_small: got act=%b busy=%b want 0 0", ro_activate, busy); end
        d_rst = 1'b0; rst = 1'b0; enable = 1'b0;
        tick(1);
        n_cmp++; if (d_ro_activate !== 1'b1 || d_busy !== 1'b1) begin n_bad++; $display("FAIL start_act: got act=%b busy=%b want 1 1", d_ro_activate, d_busy); end
        tick(79);
        n_cmp++; if (d_out_valid !== 1'b0) begin n_bad++; $display("FAIL start_early: got valid=%b want 0", d_out_valid); end
        tick(1);
        n_cmp++; if (d_out_valid !== 1'b1) begin n_bad++; $display("FAIL start_word: got valid=%b want 1", d_out_valid); end
        n_cmp++; if (d_out_data !== 8'hFF) begin n_bad++; $display("FAIL start_data: got %h want ff", d_out_data); end
        d_enable = 1'b0;
        tick(1);
        n_cmp++; if (d_ro_activate !== 1'b0 || d_out_valid !== 1'b0) begin n_bad++; $display("FAIL start_stop: got act=%b valid=%b want 0 0", d_ro_activate, d_out_valid); end
    endtask

    task automatic test_bypass;
        logic ok;
        reset_small;
        vn_bypass = 1'b1; enable = 1'b1;
        tick(4);
        feed(32'hAA, 8);
        tick(2);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL byp_early: got valid=%b want 0", out_valid); end
        tick(1);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin n_bad++; $display("FAIL byp_word: got valid=%b data=%h want 1 aa", out_valid, out_data); end
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (out_valid !== 1'b1 || out_data !== 8'hAA) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL byp_hold: got stable=%b want 1", ok); end
        out_ready = 1'b1; ro_raw = 1'b0;
        tick(1);
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL byp_ack: got valid=%b busy=%b want 0 1", out_valid, busy); end
        out_ready = 1'b0;
        tick(1);
        feed(32'h0F, 7);
        tick(2);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL byp2_early: got valid=%b want 0", out_valid); end
        tick(1);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h0F) begin n_bad++; $display("FAIL byp2_word: got valid=%b data=%h want 1 0f", out_valid, out_data); end
    endtask

    task automatic test_vn;
        reset_small;
        vn_bypass = 1'b0; enable = 1'b1;
        tick(4);
        feed(32'b01111000101001010110, 20);
        tick(2);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vn_early: got valid=%b want 0", out_valid); end
        tick(1);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h71) begin n_bad++; $display("FAIL vn_word: got valid=%b data=%h want 1 71", out_valid, out_data); end
        enable = 1'b0;
        tick(1);
        n_cmp++; if (out_valid !== 1'b0 || ro_activate !== 1'b0 || out_data !== 8'h71) begin n_bad++; $display("FAIL vn_drop: got valid=%b act=%b data=%h want 0 0 71", out_valid, ro_activate, out_data); end
    endtask

    task automatic test_health;
        logic ok;
        reset_small;
        vn_bypass = 1'b0; ro_raw = 1'b1; enable = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 68; i++) begin
            tick(1);
            if (out_valid !== 1'b0 || health_fail !== 1'b0) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1 || ro_activate !== 1'b1) begin n_bad++; $display("FAIL hlt_pre: got clean=%b act=%b want 1 1", ok, ro_activate); end
        tick(1);
        n_cmp++; if (health_fail !== 1'b1 || ro_activate !== 1'b0) begin n_bad++; $display("FAIL hlt_trip: got fail=%b act=%b want 1 0", health_fail, ro_activate); end
        n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++; $display("FAIL hlt_outs: got busy=%b valid=%b data=%h want 0 0 00", busy, out_valid, out_data); end
        enable = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(5);
        n_cmp++; if (health_fail !== 1'b1 || ro_activate !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL hlt_sticky: got fail=%b act=%b busy=%b want 1 0 0", health_fail, ro_activate, busy); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0; enable = 1'b0;
        n_cmp++; if (health_fail !== 1'b0) begin n_bad++; $display("FAIL hlt_clear: got %b want 0", health_fail); end
    endtask

    task automatic test_abort;
        reset_small;
        vn_bypass = 1'b1; enable = 1'b1;
        tick(4);
        feed(32'h1F, 5);
        tick(3);
        enable = 1'b0;
        tick(1);
        n_cmp++; if (ro_activate !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL abt_idle: got act=%b busy=%b valid=%b want 0 0 0", ro_activate, busy, out_valid); end
        enable = 1'b1;
        tick(4);
        feed(32'h3C, 8);
        tick(2);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abt_early: got valid=%b want 0", out_valid); end
        tick(1);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin n_bad++; $display("FAIL abt_word: got valid=%b data=%h want 1 3c", out_valid, out_data); end
    endtask

    task automatic test_back_to_back;
        logic ok;
        out_ready = 1'b0; ro_raw = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (out_valid !== 1'b1 || out_data !== 8'h3C || health_fail !== 1'b0) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got stable=%b want 1", ok); end
        enable = 1'b0;
        tick(1);
        n_cmp++; if (out_valid !== 1'b0 || ro_activate !== 1'b0 || out_data !== 8'h3C) begin n_bad++; $display("FAIL bp_drop: got valid=%b act=%b data=%h want 0 0 3c", out_valid, ro_activate, out_data); end
    endtask

    initial begin
        test_reset;
        test_bypass;
        test_vn;
        test_health;
        test_abort;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
